// File: rtl/riscv_hwloop_controller.sv
// Hardware-loop consumer: matches ID-stage addresses against loop end addresses,
// issues one-hot counter decrements and holds a jump-to-start request until IF acknowledges it.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | watching retiring instructions for a loop-end match
//  JUMP_PEND | redirect to the captured loop start is held until ack/kill
module riscv_hwloop_controller #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid_i,
    input  logic [31:0]            instr_addr_i,
    input  logic                   kill_i,
    input  logic [N_REGS*32-1:0]   hwlp_start_addr_i,
    input  logic [N_REGS*32-1:0]   hwlp_end_addr_i,
    input  logic [N_REGS*32-1:0]   hwlp_counter_i,
    output logic [N_REGS-1:0]      hwlp_dec_cnt_o,
    output logic [N_REGS-1:0]      hwlp_active_o,
    output logic                   jump_req_o,
    output logic [31:0]            jump_target_o,
    output logic [N_REG_BITS-1:0]  jump_idx_o,
    input  logic                   jump_ack_i
);

    typedef enum logic {
        IDLE      = 1'b0,
        JUMP_PEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             target_q, target_d;
    logic [N_REG_BITS-1:0]   idx_q, idx_d;
    logic [N_REGS-1:0]       dec_cnt;

    logic [N_REGS-1:0]       match;
    logic                    win_found;
    logic [N_REG_BITS-1:0]   win_idx;
    logic [31:0]             win_cnt;
    logic [31:0]             win_start;

    always_comb begin
        for (int k = 0; k < N_REGS; k++) begin
            hwlp_active_o[k] = (hwlp_counter_i[k*32 +: 32] != 32'd0);
            match[k] = instr_valid_i && !kill_i
                       && (instr_addr_i[31:1] == hwlp_end_addr_i[k*32+1 +: 31])
                       && (hwlp_counter_i[k*32 +: 32] != 32'd0);
        end
    end

    // Scan from the outermost loop down so the innermost match is the one left standing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_cnt   = '0;
        win_start = '0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (match[k]) begin
                win_found = 1'b1;
                win_idx   = N_REG_BITS'(k);
                win_cnt   = hwlp_counter_i[k*32 +: 32];
                win_start = hwlp_start_addr_i[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        idx_d    = idx_q;
        dec_cnt  = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    dec_cnt = N_REGS'(1) << win_idx;
                    if (win_cnt >= 32'd2) begin
                        state_d  = JUMP_PEND;
                        target_d = win_start;
                        idx_d    = win_idx;
                    end
                end
            end
            JUMP_PEND: begin
                // Instructions seen here are on the wrong path, so no decrements.
                if (kill_i || jump_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The strobe is combinational, so it is masked to stay quiet while reset is held.
    assign hwlp_dec_cnt_o = dec_cnt & {N_REGS{rst_n}};
    assign jump_req_o     = (state_q == JUMP_PEND);
    assign jump_target_o  = target_q;
    assign jump_idx_o     = idx_q;

    a_dec_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $countones(hwlp_dec_cnt_o) <= 1);
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (jump_req_o && !jump_ack_i && !kill_i) |=>
        (jump_req_o && $stable(jump_target_o) && $stable(jump_idx_o)));

endmodule

// File: tb/tb_riscv_hwloop_controller.sv
// Bench for riscv_hwloop_controller: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural model.
module tb_riscv_hwloop_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid_i;
    logic [31:0] instr_addr_i;
    logic        kill_i;
    logic [63:0] hwlp_start_addr_i;
    logic [63:0] hwlp_end_addr_i;
    logic [63:0] hwlp_counter_i;
    logic [1:0]  hwlp_dec_cnt_o;
    logic [1:0]  hwlp_active_o;
    logic        jump_req_o;
    logic [31:0] jump_target_o;
    logic [0:0]  jump_idx_o;
    logic        jump_ack_i;

    always #5 clk = ~clk;

    riscv_hwloop_controller #(.N_REGS(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_valid_i     (instr_valid_i),
        .instr_addr_i      (instr_addr_i),
        .kill_i            (kill_i),
        .hwlp_start_addr_i (hwlp_start_addr_i),
        .hwlp_end_addr_i   (hwlp_end_addr_i),
        .hwlp_counter_i    (hwlp_counter_i),
        .hwlp_dec_cnt_o    (hwlp_dec_cnt_o),
        .hwlp_active_o     (hwlp_active_o),
        .jump_req_o        (jump_req_o),
        .jump_target_o     (jump_target_o),
        .jump_idx_o        (jump_idx_o),
        .jump_ack_i        (jump_ack_i)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] s [2];
    logic [31:0] e [2];
    logic [31:0] c [2];

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic        kill;
        logic        ack;
        logic [31:0] s0, e0, c0, s1, e1, c1;
        logic [1:0]  dec;
        logic        req;
        logic [31:0] tgt;
        logic        idx;
        logic [1:0]  act;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic valid, logic [31:0] addr, logic kill, logic ack,
                                logic [31:0] s0, logic [31:0] e0, logic [31:0] c0,
                                logic [31:0] s1, logic [31:0] e1, logic [31:0] c1,
                                logic [1:0] dec, logic req, logic [31:0] tgt, logic idx,
                                logic [1:0] act);
        vec_t v;
        v.valid = valid; v.addr = addr; v.kill = kill; v.ack = ack;
        v.s0 = s0; v.e0 = e0; v.c0 = c0; v.s1 = s1; v.e1 = e1; v.c1 = c1;
        v.dec = dec; v.req = req; v.tgt = tgt; v.idx = idx; v.act = act;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        hwlp_start_addr_i = {s[1], s[0]};
        hwlp_end_addr_i   = {e[1], e[0]};
        hwlp_counter_i    = {c[1], c[0]};
    endtask

    task automatic apply_row(input vec_t v, input int n);
        @(negedge clk);
        instr_valid_i = v.valid; instr_addr_i = v.addr; kill_i = v.kill; jump_ack_i = v.ack;
        s[0] = v.s0; e[0] = v.e0; c[0] = v.c0; s[1] = v.s1; e[1] = v.e1; c[1] = v.c1;
        drive();
        #1;
        chk($sformatf("row%0d_dec", n), 32'(hwlp_dec_cnt_o), 32'(v.dec));
        chk($sformatf("row%0d_req", n), 32'(jump_req_o),     32'(v.req));
        chk($sformatf("row%0d_tgt", n), jump_target_o,       v.tgt);
        chk($sformatf("row%0d_idx", n), 32'(jump_idx_o),     32'(v.idx));
        chk($sformatf("row%0d_act", n), 32'(hwlp_active_o),  32'(v.act));
    endtask

    // Behavioural reference state for the random phase
    bit          m_pend;
    logic [31:0] m_tgt;
    int          m_idx;

    initial begin
        int jumps;
        rst_n = 1'b0; instr_valid_i = 1'b0; instr_addr_i = '0; kill_i = 1'b0; jump_ack_i = 1'b0;
        for (int k = 0; k < 2; k++) begin s[k] = '0; e[k] = '0; c[k] = '0; end
        drive();
        #1;
        chk("rst_req", 32'(jump_req_o), 0);
        chk("rst_tgt", jump_target_o, 0);
        chk("rst_idx", 32'(jump_idx_o), 0);
        chk("rst_dec", 32'(hwlp_dec_cnt_o), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // L0 loop with three iterations, then an inactive loop
        vt.push_back(mk(1, 32'h10C, 0, 0, 32'h100, 32'h10C, 3, 32'h200, 32'h20C, 0, 2'b01, 0, 32'h000, 0, 2'b01));
        vt.push_back(mk(0, 32'h000, 0, 1, 32'h100, 32'h10C, 2, 32'h200, 32'h20C, 0, 2'b00, 1, 32'h100, 0, 2'b01));
        vt.push_back(mk(1, 32'h10C, 0, 0, 32'h100, 32'h10C, 2, 32'h200, 32'h20C, 0, 2'b01, 0, 32'h100, 0, 2'b01));
        vt.push_back(mk(0, 32'h000, 0, 1, 32'h100, 32'h10C, 1, 32'h200, 32'h20C, 0, 2'b00, 1, 32'h100, 0, 2'b01));
        vt.push_back(mk(1, 32'h10C, 0, 0, 32'h100, 32'h10C, 1, 32'h200, 32'h20C, 0, 2'b01, 0, 32'h100, 0, 2'b01));
        vt.push_back(mk(0, 32'h000, 0, 0, 32'h100, 32'h10C, 0, 32'h200, 32'h20C, 0, 2'b00, 0, 32'h100, 0, 2'b00));
        vt.push_back(mk(1, 32'h10D, 0, 0, 32'h100, 32'h10C, 0, 32'h200, 32'h20C, 0, 2'b00, 0, 32'h100, 0, 2'b00));
        // Shared end address: innermost wins; then outer loop alone
        vt.push_back(mk(1, 32'h120, 0, 0, 32'h300, 32'h120, 2, 32'h400, 32'h120, 5, 2'b01, 0, 32'h100, 0, 2'b11));
        vt.push_back(mk(0, 32'h000, 0, 1, 32'h300, 32'h120, 2, 32'h400, 32'h120, 5, 2'b00, 1, 32'h300, 0, 2'b11));
        vt.push_back(mk(0, 32'h000, 0, 0, 32'h300, 32'h120, 2, 32'h400, 32'h120, 5, 2'b00, 0, 32'h300, 0, 2'b11));
        vt.push_back(mk(1, 32'h121, 0, 0, 32'h300, 32'h120, 0, 32'h400, 32'h120, 5, 2'b10, 0, 32'h300, 0, 2'b10));
        vt.push_back(mk(0, 32'h000, 0, 1, 32'h300, 32'h120, 0, 32'h400, 32'h120, 4, 2'b00, 1, 32'h400, 1, 2'b10));
        vt.push_back(mk(0, 32'h000, 0, 0, 32'h300, 32'h120, 0, 32'h400, 32'h120, 4, 2'b00, 0, 32'h400, 1, 2'b10));
        // Kill in IDLE, then kill (with ack) while pending
        vt.push_back(mk(1, 32'h120, 1, 0, 32'h300, 32'h120, 2, 32'h400, 32'h140, 0, 2'b00, 0, 32'h400, 1, 2'b01));
        vt.push_back(mk(0, 32'h000, 0, 0, 32'h300, 32'h120, 2, 32'h400, 32'h140, 0, 2'b00, 0, 32'h400, 1, 2'b01));
        vt.push_back(mk(1, 32'h120, 0, 0, 32'h300, 32'h120, 2, 32'h400, 32'h140, 0, 2'b01, 0, 32'h400, 1, 2'b01));
        vt.push_back(mk(1, 32'h120, 1, 1, 32'h300, 32'h120, 1, 32'h400, 32'h140, 0, 2'b00, 1, 32'h300, 0, 2'b01));
        vt.push_back(mk(0, 32'h000, 0, 0, 32'h300, 32'h120, 1, 32'h400, 32'h140, 0, 2'b00, 0, 32'h300, 0, 2'b01));

        for (int i = 0; i < vt.size(); i++) apply_row(vt[i], i);

        // Jump pending with ack withheld; matches must be suppressed, start rewrite ignored
        @(negedge clk);
        s[0] = 32'h100; e[0] = 32'h10C; c[0] = 3; c[1] = 0;
        instr_valid_i = 1; instr_addr_i = 32'h10C; kill_i = 0; jump_ack_i = 0;
        drive(); #1;
        chk("s3_first_dec", 32'(hwlp_dec_cnt_o), 1);
        jumps = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c[0] = 2; s[0] = 32'h555; drive(); #1;
            chk("s3_hold_req", 32'(jump_req_o), 1);
            chk("s3_hold_tgt", jump_target_o, 32'h100);
            chk("s3_hold_dec", 32'(hwlp_dec_cnt_o), 0);
        end
        @(negedge clk);
        jump_ack_i = 1; #1;
        chk("s3_ack_req", 32'(jump_req_o), 1);
        chk("s3_ack_dec", 32'(hwlp_dec_cnt_o), 0);
        @(posedge clk);
        if (jump_req_o && jump_ack_i) jumps++;
        @(negedge clk);
        jump_ack_i = 0; instr_valid_i = 0; #1;
        if (jump_req_o && jump_ack_i) jumps++;
        chk("s3_req_dropped", 32'(jump_req_o), 0);
        chk("s3_jump_count", 32'(jumps), 1);

        // Reset while a request is pending
        @(negedge clk);
        s[0] = 32'h100; e[0] = 32'h10C; c[0] = 3; c[1] = 0;
        instr_valid_i = 1; instr_addr_i = 32'h10C; drive(); #1;
        chk("s6_pre_dec", 32'(hwlp_dec_cnt_o), 1);
        @(negedge clk);
        #1;
        chk("s6_pre_req", 32'(jump_req_o), 1);
        rst_n = 0; #1;
        chk("s6_rst_req", 32'(jump_req_o), 0);
        chk("s6_rst_tgt", jump_target_o, 0);
        chk("s6_rst_idx", 32'(jump_idx_o), 0);
        chk("s6_rst_dec", 32'(hwlp_dec_cnt_o), 0);
        @(negedge clk);
        rst_n = 1; instr_valid_i = 0;
        for (int i = 0; i < 5; i++) apply_row(vt[i], 100 + i);

        // Randomized traffic against the model
        m_pend = 0; m_tgt = 32'h100; m_idx = 0;
        for (int n = 0; n < 400; n++) begin
            int w;
            logic [1:0] exp_dec;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int r;
                r = $urandom_range(7);
                if (r == 0) c[k] = 0;
                else if (r == 1) c[k] = 1;
                else if (r == 2) c[k] = 2;
                else if (r == 3) c[k] = $urandom;
                else c[k] = $urandom_range(20);
                e[k] = 32'h1000 + 32'($urandom_range(3)) * 4;
                s[k] = $urandom;
            end
            instr_valid_i = 1'($urandom_range(1));
            instr_addr_i  = 32'h1000 + 32'($urandom_range(3)) * 4 + 32'($urandom_range(1));
            kill_i        = ($urandom_range(7) == 0);
            jump_ack_i    = ($urandom_range(2) == 0);
            drive(); #1;

            w = -1;
            exp_dec = '0;
            if (!m_pend) begin
                for (int k = 0; k < 2; k++)
                    if (w < 0 && instr_valid_i && !kill_i && instr_addr_i[31:1] == e[k][31:1] && c[k] != 0)
                        w = k;
                if (w >= 0) exp_dec[w] = 1'b1;
            end
            chk("rnd_dec", 32'(hwlp_dec_cnt_o), 32'(exp_dec));
            chk("rnd_req", 32'(jump_req_o), 32'(m_pend));
            chk("rnd_tgt", jump_target_o, m_tgt);
            chk("rnd_idx", 32'(jump_idx_o), 32'(m_idx));
            chk("rnd_act", 32'(hwlp_active_o), {30'd0, c[1] != 0, c[0] != 0});

            @(posedge clk);
            if (m_pend) begin
                if (kill_i || jump_ack_i) m_pend = 0;
            end else if (w >= 0 && c[w] >= 2) begin
                m_pend = 1; m_tgt = s[w]; m_idx = w;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
